// File: rtl/chan_csr_bank_pkg.sv
// Shared definitions for the per-channel CSR bank: word offsets, CTRL bit
// positions and the Wishbone address decoder.
package chan_csr_bank_pkg;

  localparam int CHANNELS_MAX   = 16;
  localparam int CTRL_RST_BIT   = 31;
  localparam int CTRL_IRQEN_BIT = 30;

  // Word addresses (byte offset >> 2); word 3 is reserved and decodes to SEL_NONE.
  localparam logic [5:0] ADR_CTRL      = 6'd0;
  localparam logic [5:0] ADR_STATUS    = 6'd1;
  localparam logic [5:0] ADR_MASK      = 6'd2;
  localparam logic [5:0] ADR_CHAN_BASE = 6'd4;
  localparam logic [5:0] ADR_CHAN_END  = ADR_CHAN_BASE + 6'(2 * CHANNELS_MAX);

  typedef enum logic [2:0] {
    SEL_NONE, SEL_CTRL, SEL_STATUS, SEL_MASK, SEL_CNT, SEL_HWM
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [3:0] ch;
  } reg_dec_t;

  // Per-channel registers come in CNT/HWM pairs, so bit 0 picks the register
  // and the remaining offset bits pick the channel.
  function automatic reg_dec_t decode_adr(input logic [5:0] adr);
    reg_dec_t d;
    d.sel = SEL_NONE;
    d.ch  = '0;
    case (adr)
      ADR_CTRL:   d.sel = SEL_CTRL;
      ADR_STATUS: d.sel = SEL_STATUS;
      ADR_MASK:   d.sel = SEL_MASK;
      default: begin
        if (adr >= ADR_CHAN_BASE && adr < ADR_CHAN_END) begin
          d.sel = adr[0] ? SEL_HWM : SEL_CNT;
          d.ch  = 4'((adr - ADR_CHAN_BASE) >> 1);
        end
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/chan_csr_bank_if.sv
// Wishbone slave port bundle for the channel CSR bank.
interface chan_csr_bank_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [5:0]  wb_adr;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack;

  modport master (output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
                  input  wb_dat_o, wb_ack);
  modport slave  (input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
                  output wb_dat_o, wb_ack);
endinterface

// File: rtl/chan_stat.sv
// One channel's sticky overflow bit (write-1-to-clear) and FIFO high-water mark.
module chan_stat #(
  parameter int CNT_W = 16
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic             ovf,
  input  logic             w1c,
  input  logic             hwm_ld,
  output logic             sticky,
  output logic [CNT_W-1:0] hwm
);

  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] hwm_q, hwm_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sticky_d = sticky_q;
    hwm_d    = hwm_q;
    if (w1c) sticky_d = 1'b0;
    // A live overflow wins over a clear in the same cycle so no event is lost.
    if (ovf) sticky_d = 1'b1;
    if (hwm_ld || cnt > hwm_q) hwm_d = cnt;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      sticky_q <= 1'b0;
      hwm_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      hwm_q    <= hwm_d;
    end
  end

  assign sticky = sticky_q;
  assign hwm    = hwm_q;

endmodule

// File: rtl/chan_csr_bank.sv
// Wishbone status/control bank for CHANNELS receive channels: decode, read mux,
// CTRL/MASK, interrupt and the self-timed chan_rst pulse.
module chan_csr_bank
  import chan_csr_bank_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int RST_LEN  = 125
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  chan_csr_bank_if.slave         wb,
  input  logic [CHANNELS*16-1:0] fifo_cnt,
  input  logic [CHANNELS-1:0]    overflow,
  output logic                   irq,
  output logic                   chan_rst
);

  logic                           ack_q, ack_d;
  logic [31:0]                    dat_q, dat_d;
  logic                           irq_q, irq_d;
  logic                           irqen_q, irqen_d;
  logic [15:0]                    scratch_q, scratch_d;
  logic [CHANNELS-1:0]            mask_q, mask_d;
  logic [15:0]                    rst_cnt_q, rst_cnt_d;
  logic                           chan_rst_q, chan_rst_d;

  logic                           access, wr;
  reg_dec_t                       dec;
  logic                           hwm_wr;
  logic [CHANNELS-1:0]            w1c, hwm_ld, sticky;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_vec, hwm_vec;
  logic [31:0]                    rd_data;
  logic                           unused_dat;

  // The !ack_q term turns a held strobe into exactly one ack per access.
  assign access = wb.wb_cyc & wb.wb_stb & ~ack_q;
  assign wr     = access & wb.wb_we;
  assign dec    = decode_adr(wb.wb_adr);
  assign hwm_wr = wr && (dec.sel == SEL_HWM);
  assign w1c    = (wr && dec.sel == SEL_STATUS) ? wb.wb_dat_i[CHANNELS-1:0] : '0;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    assign cnt_vec[k] = fifo_cnt[16*k +: CNT_W];
    assign hwm_ld[k]  = hwm_wr && (dec.ch == 4'(k));
    chan_stat #(.CNT_W(CNT_W)) u_stat (
      .wb_clk (wb_clk),
      .wb_rst (wb_rst),
      .cnt    (cnt_vec[k]),
      .ovf    (overflow[k]),
      .w1c    (w1c[k]),
      .hwm_ld (hwm_ld[k]),
      .sticky (sticky[k]),
      .hwm    (hwm_vec[k])
    );
  end

  // Channels at or beyond CHANNELS match no loop index and read as zero.
  always_comb begin
    rd_data = '0;
    case (dec.sel)
      SEL_CTRL: begin
        rd_data[CTRL_RST_BIT]   = chan_rst_q;
        rd_data[CTRL_IRQEN_BIT] = irqen_q;
        rd_data[15:0]           = scratch_q;
      end
      SEL_STATUS: rd_data[CHANNELS-1:0] = sticky;
      SEL_MASK:   rd_data[CHANNELS-1:0] = mask_q;
      SEL_CNT: begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (dec.ch == 4'(k)) begin
            rd_data[31]        = overflow[k];
            rd_data[30]        = sticky[k];
            rd_data[CNT_W-1:0] = cnt_vec[k];
          end
        end
      end
      SEL_HWM: begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (dec.ch == 4'(k)) rd_data[CNT_W-1:0] = hwm_vec[k];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ack_d     = access;
    dat_d     = dat_q;
    irqen_d   = irqen_q;
    scratch_d = scratch_q;
    mask_d    = mask_q;
    rst_cnt_d = (rst_cnt_q != '0) ? rst_cnt_q - 16'd1 : '0;
    if (access) dat_d = rd_data;
    if (wr && dec.sel == SEL_CTRL) begin
      irqen_d   = wb.wb_dat_i[CTRL_IRQEN_BIT];
      scratch_d = wb.wb_dat_i[15:0];
      // A reload while the pulse is running simply extends it.
      if (wb.wb_dat_i[CTRL_RST_BIT]) rst_cnt_d = 16'(RST_LEN);
    end
    if (wr && dec.sel == SEL_MASK) mask_d = wb.wb_dat_i[CHANNELS-1:0];
    chan_rst_d = (rst_cnt_d != '0);
    irq_d      = irqen_q & |(sticky & mask_q);
  end

  // NOTE: every flop here is a control/status register, so all of them take the reset value.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      irq_q      <= 1'b0;
      irqen_q    <= 1'b0;
      scratch_q  <= '0;
      mask_q     <= '0;
      rst_cnt_q  <= '0;
      chan_rst_q <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      irq_q      <= irq_d;
      irqen_q    <= irqen_d;
      scratch_q  <= scratch_d;
      mask_q     <= mask_d;
      rst_cnt_q  <= rst_cnt_d;
      chan_rst_q <= chan_rst_d;
    end
  end

  assign wb.wb_ack   = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq         = irq_q;
  assign chan_rst    = chan_rst_q;
  assign unused_dat  = ^wb.wb_dat_i[29:16];

endmodule

// File: tb/tb_chan_csr_bank.sv
// Self-checking bench for chan_csr_bank: directed scenarios plus a randomized
// phase, all compared every cycle against a register-level behavioural model.
module tb_chan_csr_bank;

  localparam int CH = 4;
  localparam int CW = 16;
  localparam int RL = 125;

  logic             wb_clk;
  logic             wb_rst;
  logic [CH*16-1:0] fifo_cnt;
  logic [CH-1:0]    overflow;
  logic             irq;
  logic             chan_rst;

  chan_csr_bank_if bus();

  chan_csr_bank #(.CHANNELS(CH), .CNT_W(CW), .RST_LEN(RL)) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .wb       (bus),
    .fifo_cnt (fifo_cnt),
    .overflow (overflow),
    .irq      (irq),
    .chan_rst (chan_rst)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: register map contents ----------------
  bit          m_sticky [CH];
  int          m_hwm    [CH];
  bit          m_mask   [CH];
  bit          m_irqen;
  int          m_scratch;
  int          m_rst_rem;
  bit          m_ack, m_irq, m_rd;
  logic [31:0] m_rdata;

  function automatic logic [31:0] exp_read(input int word);
    logic [31:0] v;
    int k;
    v = 32'd0;
    if (word == 0) begin
      v[31] = (m_rst_rem > 0);
      v[30] = m_irqen;
      v[15:0] = 16'(m_scratch);
    end else if (word == 1) begin
      for (int i = 0; i < CH; i++) v[i] = m_sticky[i];
    end else if (word == 2) begin
      for (int i = 0; i < CH; i++) v[i] = m_mask[i];
    end else if (word >= 4 && word < 36) begin
      k = (word - 4) / 2;
      if (k < CH) begin
        if (word % 2 == 0) begin
          v[31] = overflow[k];
          v[30] = m_sticky[k];
          v[15:0] = fifo_cnt[16*k +: 16];
        end else begin
          v[15:0] = 16'(m_hwm[k]);
        end
      end
    end
    return v;
  endfunction

  always @(posedge wb_clk) begin
    bit acc, wr, any;
    int word, cnt;
    if (wb_rst) begin
      for (int k = 0; k < CH; k++) begin
        m_sticky[k] = 1'b0; m_hwm[k] = 0; m_mask[k] = 1'b0;
      end
      m_irqen = 0; m_scratch = 0; m_rst_rem = 0;
      m_ack = 0; m_irq = 0; m_rd = 0;
    end else begin
      acc  = bus.wb_cyc && bus.wb_stb && !m_ack;
      wr   = acc && bus.wb_we;
      word = int'(bus.wb_adr);
      any  = 1'b0;
      for (int k = 0; k < CH; k++) any |= m_sticky[k] & m_mask[k];
      m_irq = m_irqen && any;
      m_rd  = acc && !bus.wb_we;
      if (m_rd) m_rdata = exp_read(word);
      for (int k = 0; k < CH; k++) begin
        cnt = int'(fifo_cnt[16*k +: 16]);
        if (overflow[k]) m_sticky[k] = 1'b1;
        else if (wr && word == 1 && bus.wb_dat_i[k]) m_sticky[k] = 1'b0;
        if (wr && word == 5 + 2*k) m_hwm[k] = cnt;
        else if (cnt > m_hwm[k]) m_hwm[k] = cnt;
      end
      if (wr && word == 0 && bus.wb_dat_i[31]) m_rst_rem = RL;
      else if (m_rst_rem > 0) m_rst_rem--;
      if (wr && word == 0) begin
        m_irqen   = bus.wb_dat_i[30];
        m_scratch = int'(bus.wb_dat_i[15:0]);
      end
      if (wr && word == 2) for (int k = 0; k < CH; k++) m_mask[k] = bus.wb_dat_i[k];
      m_ack = acc;
    end
  end

  // Compare process: outputs checked on the falling edge of every cycle.
  always @(negedge wb_clk) begin
    if (chk_en) begin
      check("ack", {31'd0, bus.wb_ack}, {31'd0, m_ack});
      check("irq", {31'd0, irq}, {31'd0, m_irq});
      check("chan_rst", {31'd0, chan_rst}, {31'd0, (m_rst_rem > 0)});
      if (m_ack && m_rd) check("rdata", bus.wb_dat_o, m_rdata);
    end
  end

  // Measures the length of each chan_rst pulse in cycles.
  int pulse_run = 0;
  int pulse_len = 0;
  always @(negedge wb_clk) begin
    if (chan_rst) pulse_run++;
    else if (pulse_run > 0) begin
      pulse_len = pulse_run;
      pulse_run = 0;
    end
  end

  // ---------------- bus tasks: called on a falling edge ----------------
  task automatic wb_access(input logic [7:0] badr, input bit we, input logic [31:0] wdat,
                           output logic [31:0] rdat);
    bit got;
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = we;
    bus.wb_adr = badr[7:2]; bus.wb_dat_i = wdat;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge wb_clk);
      if (bus.wb_ack) got = 1'b1;
    end
    rdat = bus.wb_dat_o;
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    check("ack_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic wr(input logic [7:0] badr, input logic [31:0] wdat);
    logic [31:0] d;
    wb_access(badr, 1'b1, wdat, d);
  endtask

  task automatic rd(input logic [7:0] badr, input logic [31:0] exp, input string name);
    logic [31:0] d;
    wb_access(badr, 1'b0, 32'd0, d);
    check(name, d, exp);
  endtask

  task automatic wait_rst_low();
    int n;
    n = 0;
    while (chan_rst && n < 400) begin
      @(negedge wb_clk);
      n++;
    end
    check("chan_rst_ends", {31'd0, chan_rst}, 32'd0);
    @(negedge wb_clk);
  endtask

  initial begin
    int wait_cnt;
    wb_rst = 1'b1;
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    bus.wb_adr = '0; bus.wb_dat_i = '0;
    fifo_cnt = '0; overflow = '0;
    repeat (3) @(negedge wb_clk);
    chk_en = 1'b1;
    check("rst_dat_o", bus.wb_dat_o, 32'd0);
    check("rst_ack", {31'd0, bus.wb_ack}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_chan_rst", {31'd0, chan_rst}, 32'd0);
    wb_rst = 1'b0;
    @(negedge wb_clk);

    // Reset values through the bus
    rd(8'h00, 32'd0, "ctrl_rst");
    rd(8'h04, 32'd0, "status_rst");
    rd(8'h08, 32'd0, "mask_rst");
    rd(8'h10, 32'd0, "cnt0_rst");

    // Sticky overflow and write-1-to-clear
    overflow[2] = 1'b1;
    @(negedge wb_clk);
    overflow[2] = 1'b0;
    rd(8'h04, 32'h4, "sticky_set");
    wr(8'h04, 32'h4);
    rd(8'h04, 32'h0, "sticky_w1c");
    overflow[2] = 1'b1;
    wr(8'h04, 32'h4);
    overflow[2] = 1'b0;
    rd(8'h04, 32'h4, "sticky_w1c_race");

    // Interrupt: masked channel, global enable, clear, then masked off
    wr(8'h08, 32'h4);
    wr(8'h00, 32'h4000_0000);
    wr(8'h04, 32'h4);
    overflow[2] = 1'b1;
    @(negedge wb_clk);
    overflow[2] = 1'b0;
    check("irq_lag", {31'd0, irq}, 32'd0);
    @(negedge wb_clk);
    check("irq_set", {31'd0, irq}, 32'd1);
    wr(8'h04, 32'h4);
    @(negedge wb_clk);
    check("irq_clr", {31'd0, irq}, 32'd0);
    wr(8'h08, 32'h0);
    overflow[2] = 1'b1;
    @(negedge wb_clk);
    overflow[2] = 1'b0;
    repeat (3) @(negedge wb_clk);
    check("irq_masked", {31'd0, irq}, 32'd0);
    rd(8'h04, 32'h4, "sticky_masked");
    wr(8'h04, 32'h4);

    // High-water mark on channel 1
    for (int v = 0; v <= 300; v++) begin
      fifo_cnt[31:16] = 16'(v);
      @(negedge wb_clk);
    end
    for (int v = 299; v >= 5; v--) begin
      fifo_cnt[31:16] = 16'(v);
      @(negedge wb_clk);
    end
    rd(8'h1C, 32'd300, "hwm1_peak");
    rd(8'h18, 32'd5, "cnt1_live");
    wr(8'h1C, 32'h0);
    rd(8'h1C, 32'd5, "hwm1_reload");

    // chan_rst pulse: plain, extended, and cut short by reset
    wr(8'h00, 32'h8000_0000);
    check("chan_rst_start", {31'd0, chan_rst}, 32'd1);
    rd(8'h00, 32'h8000_0000, "ctrl_rst_bit");
    wait_rst_low();
    check("pulse_125", pulse_len, 32'd125);
    wr(8'h00, 32'h8000_0000);
    repeat (99) @(negedge wb_clk);
    wr(8'h00, 32'h8000_0000);
    wait_rst_low();
    check("pulse_225", pulse_len, 32'd225);
    wr(8'h00, 32'h8000_0000);
    repeat (49) @(negedge wb_clk);
    wb_rst = 1'b1;
    @(negedge wb_clk);
    check("chan_rst_killed", {31'd0, chan_rst}, 32'd0);
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
    bus.wb_adr = 6'd0; bus.wb_dat_i = 32'h0000_1234;
    @(negedge wb_clk);
    check("ack_in_reset", {31'd0, bus.wb_ack}, 32'd0);
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    wb_rst = 1'b0;
    @(negedge wb_clk);
    rd(8'h00, 32'd0, "ctrl_lost_write");

    // Unimplemented channels, reserved word and scratch
    rd(8'h30, 32'd0, "cnt_unimpl");
    wr(8'h34, 32'hFFFF_FFFF);
    rd(8'h34, 32'd0, "hwm_unimpl");
    wr(8'h0C, 32'hFFFF_FFFF);
    rd(8'h0C, 32'd0, "reserved");
    wr(8'h00, 32'h0000_BEEF);
    rd(8'h00, 32'h0000_BEEF, "scratch");

    // Randomized traffic; the compare process checks every cycle
    wait_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge wb_clk);
      for (int k = 0; k < CH; k++) begin
        overflow[k] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0) fifo_cnt[16*k +: 16] = 16'($urandom_range(0, 4095));
      end
      if (bus.wb_cyc) begin
        if (bus.wb_ack) begin
          bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; wait_cnt = 0;
        end else begin
          wait_cnt++;
          if (wait_cnt > 8) begin
            n_tests++; n_fail++;
            $display("FAIL rand_ack_timeout: no ack after %0d cycles at %0t", wait_cnt, $time);
            bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; wait_cnt = 0;
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1;
        bus.wb_we = 1'($urandom_range(0, 1));
        bus.wb_adr = 6'($urandom_range(0, 40));
        bus.wb_dat_i = $urandom;
        if ($urandom_range(0, 15) != 0) bus.wb_dat_i[31] = 1'b0;
      end
    end
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
    overflow = '0;
    repeat (4) @(negedge wb_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
